// File: rtl/k12a_instr_sequencer.sv
// k12a per-instruction control sequencer: fetch, decode, memory-wait and halt
// phases, driving the skip-flag select and datapath strobes.

package k12a_pkg;
  typedef enum logic [1:0] {
    SKIP_SEL_HOLD        = 2'd0,
    SKIP_SEL_0           = 2'd1,
    SKIP_SEL_CONDITION   = 2'd2,
    SKIP_SEL_CONDITION_N = 2'd3
  } skip_sel_t;
endpackage

module k12a_instr_sequencer
  import k12a_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             cpu_clock,
  input  logic             reset_n,
  input  logic             skip,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             ir_is_skip,
  input  logic             ir_skip_invert,
  input  logic             ir_is_mem,
  input  logic             ir_is_write,
  input  logic             ir_reg_we,
  output skip_sel_t        skip_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             reg_we,
  output logic             squash,
  output logic             halted,
  output logic [CNT_W-1:0] squash_count
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // State, halt flag and squash counter registers.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Next-state and per-phase strobes; everything idles while reset is held,
  // since the reset state (FETCH) would otherwise assert mem_req.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    skip_sel = SKIP_SEL_HOLD;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    reg_we   = 1'b0;
    squash   = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_FETCH: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_load = 1'b1;
              pc_inc  = 1'b1;
              state_d = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          state_d = ST_FETCH;
          if (skip) begin
            squash   = 1'b1;
            skip_sel = SKIP_SEL_0;
            if (count_q != '1) count_d = count_q + 1'b1;
          end else if (ir_is_skip) begin
            skip_sel = ir_skip_invert ? SKIP_SEL_CONDITION_N : SKIP_SEL_CONDITION;
          end else if (ir_is_mem) begin
            state_d = ST_MEMWAIT;
          end else begin
            reg_we = ir_reg_we;
          end
        end
        ST_MEMWAIT: begin
          mem_req = 1'b1;
          mem_we  = ir_is_write;
          if (mem_ready) begin
            reg_we  = ir_reg_we & ~ir_is_write;
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          if (!halt_req) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // halted tracks the state being entered so it is high exactly while in HALT.
  always_comb begin
    halted_d = (state_d == ST_HALT);
  end

  assign halted       = halted_q;
  assign squash_count = count_q;

endmodule

// File: tb/tb_k12a_instr_sequencer.sv
// Scoreboard bench for k12a_instr_sequencer: the stimulus process pushes the
// expected per-cycle outputs, a monitor on the falling edge pops and compares.

module tb_k12a_instr_sequencer;
  import k12a_pkg::*;

  logic cpu_clock = 1'b0;
  logic reset_n = 1'b0;
  logic skip = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
  logic ir_is_skip = 1'b0, ir_skip_invert = 1'b0, ir_is_mem = 1'b0;
  logic ir_is_write = 1'b0, ir_reg_we = 1'b0;

  skip_sel_t  skip_sel, skip_sel2;
  logic       mem_req, mem_we, ir_load, pc_inc, reg_we, squash, halted;
  logic       mem_req2, mem_we2, ir_load2, pc_inc2, reg_we2, squash2, halted2;
  logic [7:0] squash_count;
  logic [1:0] squash_count2;

  always #5 cpu_clock = ~cpu_clock;

  k12a_instr_sequencer #(.CNT_W(8)) dut (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .skip(skip), .mem_ready(mem_ready),
    .halt_req(halt_req), .ir_is_skip(ir_is_skip), .ir_skip_invert(ir_skip_invert),
    .ir_is_mem(ir_is_mem), .ir_is_write(ir_is_write), .ir_reg_we(ir_reg_we),
    .skip_sel(skip_sel), .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
    .pc_inc(pc_inc), .reg_we(reg_we), .squash(squash), .halted(halted),
    .squash_count(squash_count)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise saturation.
  k12a_instr_sequencer #(.CNT_W(2)) dut2 (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .skip(skip), .mem_ready(mem_ready),
    .halt_req(halt_req), .ir_is_skip(ir_is_skip), .ir_skip_invert(ir_skip_invert),
    .ir_is_mem(ir_is_mem), .ir_is_write(ir_is_write), .ir_reg_we(ir_reg_we),
    .skip_sel(skip_sel2), .mem_req(mem_req2), .mem_we(mem_we2), .ir_load(ir_load2),
    .pc_inc(pc_inc2), .reg_we(reg_we2), .squash(squash2), .halted(halted2),
    .squash_count(squash_count2)
  );

  typedef struct {
    string       name;
    logic [18:0] exp;
  } item_t;

  item_t q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_cnt = 0;
  int unsigned exp_cnt2 = 0;

  // Output bundles {mem_req, mem_we, ir_load, pc_inc, reg_we, squash, halted}
  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_FETCH = 7'b101_1000;
  localparam logic [6:0] O_REQ   = 7'b100_0000;
  localparam logic [6:0] O_RWE   = 7'b000_0100;
  localparam logic [6:0] O_SQ    = 7'b000_0010;
  localparam logic [6:0] O_ST    = 7'b110_0000;
  localparam logic [6:0] O_LDONE = 7'b100_0100;
  localparam logic [6:0] O_HALT  = 7'b000_0001;

  // Inputs packed {skip, mem_ready, halt_req, is_skip, invert, is_mem, is_write, reg_we}
  localparam logic [7:0] I_ALU   = 8'b0100_0001;

  task automatic vec(input string nm, input logic rst_n, input logic [7:0] in,
                     input skip_sel_t sel, input logic [6:0] o);
    item_t it;
    @(posedge cpu_clock);
    #1;
    {skip, mem_ready, halt_req, ir_is_skip, ir_skip_invert,
     ir_is_mem, ir_is_write, ir_reg_we} = in;
    reset_n = rst_n;
    if (!rst_n) begin
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end
    it.name = nm;
    it.exp  = {sel, o, exp_cnt[7:0], exp_cnt2[1:0]};
    q.push_back(it);
    if (o[1]) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  // Monitor: one observation per cycle, compared against the queue head.
  always @(negedge cpu_clock) begin
    if (q.size() > 0) begin
      item_t it;
      logic [18:0] act;
      it  = q.pop_front();
      act = {skip_sel, mem_req, mem_we, ir_load, pc_inc, reg_we, squash, halted,
             squash_count, squash_count2};
      vectors++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got sel=%0d req/we/ld/inc/rwe/sq/hlt=%b cnt=%0d cnt2=%0d, want sel=%0d %b cnt=%0d cnt2=%0d",
                 it.name, act[18:17], act[16:10], act[9:2], act[1:0],
                 it.exp[18:17], it.exp[16:10], it.exp[9:2], it.exp[1:0]);
      end
    end
  end

  initial begin
    // Reset state
    vec("rst", 1'b0, 8'h00, SKIP_SEL_HOLD, O_NONE);
    // 1: back-to-back ALU instructions, 2 cycles each
    for (int i = 0; i < 3; i++) begin
      vec("t1_fetch", 1'b1, I_ALU, SKIP_SEL_HOLD, O_FETCH);
      vec("t1_dec",   1'b1, I_ALU, SKIP_SEL_HOLD, O_RWE);
    end
    vec("t1_fetch_wait", 1'b1, 8'b0000_0001, SKIP_SEL_HOLD, O_REQ);
    vec("t1_fetch2",     1'b1, I_ALU,        SKIP_SEL_HOLD, O_FETCH);
    vec("t1_dec2",       1'b1, I_ALU,        SKIP_SEL_HOLD, O_RWE);
    // 2: skip instruction, then squash, then inverted skip
    vec("t2_fetch",     1'b1, 8'b0100_0000, SKIP_SEL_HOLD,        O_FETCH);
    vec("t2_dec_cond",  1'b1, 8'b0101_0000, SKIP_SEL_CONDITION,   O_NONE);
    vec("t2_fetch_sk",  1'b1, 8'b1100_0001, SKIP_SEL_HOLD,        O_FETCH);
    vec("t2_dec_sq",    1'b1, 8'b1100_0001, SKIP_SEL_0,           O_SQ);
    vec("t2_fetch_inv", 1'b1, 8'b0100_0000, SKIP_SEL_HOLD,        O_FETCH);
    vec("t2_dec_condn", 1'b1, 8'b0101_1000, SKIP_SEL_CONDITION_N, O_NONE);
    // 3: store with 3 wait cycles, then load with immediate ready
    vec("t3_fetch", 1'b1, 8'b0100_0111, SKIP_SEL_HOLD, O_FETCH);
    vec("t3_dec",   1'b1, 8'b0100_0111, SKIP_SEL_HOLD, O_NONE);
    for (int i = 0; i < 3; i++)
      vec("t3_memwait", 1'b1, 8'b0000_0111, SKIP_SEL_HOLD, O_ST);
    vec("t3_st_done", 1'b1, 8'b0100_0111, SKIP_SEL_HOLD, O_ST);
    vec("t3_fetch_ld", 1'b1, 8'b0100_0101, SKIP_SEL_HOLD, O_FETCH);
    vec("t3_dec_ld",   1'b1, 8'b0100_0101, SKIP_SEL_HOLD, O_NONE);
    vec("t3_ld_done",  1'b1, 8'b0100_0101, SKIP_SEL_HOLD, O_LDONE);
    // 4: five consecutive squashes (ALU, skip, mem, ALU, ALU)
    vec("t4_fetch", 1'b1, 8'b1100_0001, SKIP_SEL_HOLD, O_FETCH);
    vec("t4_sq_alu", 1'b1, 8'b1100_0001, SKIP_SEL_0, O_SQ);
    vec("t4_fetch", 1'b1, 8'b1100_0001, SKIP_SEL_HOLD, O_FETCH);
    vec("t4_sq_skip", 1'b1, 8'b1101_0000, SKIP_SEL_0, O_SQ);
    vec("t4_fetch", 1'b1, 8'b1100_0001, SKIP_SEL_HOLD, O_FETCH);
    vec("t4_sq_mem", 1'b1, 8'b1100_0111, SKIP_SEL_0, O_SQ);
    for (int i = 0; i < 2; i++) begin
      vec("t4_fetch", 1'b1, 8'b1100_0001, SKIP_SEL_HOLD, O_FETCH);
      vec("t4_sq_alu", 1'b1, 8'b1100_0001, SKIP_SEL_0, O_SQ);
    end
    // 5: halt takes priority over mem_ready; skip flag held during HALT
    vec("t5_fetch_halt", 1'b1, 8'b0110_0000, SKIP_SEL_HOLD, O_NONE);
    vec("t5_halt",       1'b1, 8'b1110_0000, SKIP_SEL_HOLD, O_HALT);
    vec("t5_halt_rel",   1'b1, 8'b0100_0000, SKIP_SEL_HOLD, O_HALT);
    vec("t5_fetch",      1'b1, I_ALU,        SKIP_SEL_HOLD, O_FETCH);
    vec("t5_dec",        1'b1, I_ALU,        SKIP_SEL_HOLD, O_RWE);
    // 6: asynchronous reset in MEMWAIT
    vec("t6_fetch",   1'b1, 8'b0100_0111, SKIP_SEL_HOLD, O_FETCH);
    vec("t6_dec",     1'b1, 8'b0100_0111, SKIP_SEL_HOLD, O_NONE);
    vec("t6_memwait", 1'b1, 8'b0000_0111, SKIP_SEL_HOLD, O_ST);
    vec("t6_reset",   1'b0, 8'b0100_0111, SKIP_SEL_HOLD, O_NONE);
    vec("t6_rel_req", 1'b1, 8'b0000_0001, SKIP_SEL_HOLD, O_REQ);
    vec("t6_fetch",   1'b1, I_ALU,        SKIP_SEL_HOLD, O_FETCH);
    vec("t6_dec",     1'b1, I_ALU,        SKIP_SEL_HOLD, O_RWE);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge cpu_clock);
    @(posedge cpu_clock);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
